// File: rtl/bcd_updn_counter.sv
// Cascaded BCD up/down counter with parallel load, clear, and wrap or saturate at terminal values.
// Out-of-range load digits are stored as zero and flagged on load_err for one cycle.
module bcd_updn_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up_dn,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap_p,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] q_q, q_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;

    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_fix;
    logic [DIGITS:0]     carry;
    logic                load_bad;
    logic                all9, all0;

    // Terminal detection and the single-cycle ripple step in the requested direction.
    always_comb begin
        all9     = 1'b1;
        all0     = 1'b1;
        carry    = '0;
        carry[0] = 1'b1;
        step_val = q_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (q_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (q_q[4*i +: 4] != 4'd0) all0 = 1'b0;
            if (carry[i]) begin
                if (up_dn) begin
                    if (q_q[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                        carry[i+1]         = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                    end
                end else begin
                    if (q_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                        carry[i+1]         = 1'b1;
                    end else begin
                        step_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        load_bad = 1'b0;
        load_fix = load_val;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_fix[4*i +: 4] = 4'd0;
                load_bad           = 1'b1;
            end
        end
    end

    // Priority: clear, load, count, hold. Reset is applied in the register block.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d   = load_fix;
            err_d = load_bad;
        end else if (en) begin
            if (up_dn ? all9 : all0) begin
                wrap_d = 1'b1;
                q_d    = WRAP ? step_val : q_q;
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q        = q_q;
    assign tc       = (up_dn && all9) || (!up_dn && all0);
    assign wrap_p   = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_updn_counter.sv
// Scoreboard bench for bcd_updn_counter: three instances (2-digit wrap, 2-digit saturate,
// 4-digit wrap) share stimulus and are checked against an integer-valued reference model.
module tb_bcd_updn_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, load, en, up_dn;
    logic [15:0] lv;

    logic [7:0]  q_a, q_b;
    logic [15:0] q_c;
    logic        tc_a, tc_b, tc_c;
    logic        w_a, w_b, w_c;
    logic        e_a, e_b, e_c;

    bcd_updn_counter #(.DIGITS(2), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(lv[7:0]),
        .en(en), .up_dn(up_dn), .q(q_a), .tc(tc_a), .wrap_p(w_a), .load_err(e_a)
    );
    bcd_updn_counter #(.DIGITS(2), .WRAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(lv[7:0]),
        .en(en), .up_dn(up_dn), .q(q_b), .tc(tc_b), .wrap_p(w_b), .load_err(e_b)
    );
    bcd_updn_counter #(.DIGITS(4), .WRAP(1'b1)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(lv),
        .en(en), .up_dn(up_dn), .q(q_c), .tc(tc_c), .wrap_p(w_c), .load_err(e_c)
    );

    typedef struct {
        int unsigned qa, qb, qc;
        bit          wa, wb, wc;
        bit          ea, eb, ec;
    } exp_t;

    exp_t        sb[$];
    int unsigned ma, mb, mc;
    int          checks = 0;
    int          errors = 0;

    // Reference model: the count is a plain integer in 0 .. 10**nd-1.
    function automatic void mstep(input int unsigned nd, input bit wr, input int unsigned cur,
                                  output int unsigned nxt, output bit w, output bit e);
        int unsigned top, pw, d;
        top = 1;
        for (int i = 0; i < int'(nd); i++) top = top * 10;
        top = top - 1;
        nxt = cur;
        w   = 1'b0;
        e   = 1'b0;
        if (!reset) begin
            nxt = 0;
        end else if (clear) begin
            nxt = 0;
        end else if (load) begin
            nxt = 0;
            pw  = 1;
            for (int i = 0; i < int'(nd); i++) begin
                d = (32'(lv) >> (4 * i)) & 32'hF;
                if (d > 9) begin
                    e = 1'b1;
                    d = 0;
                end
                nxt = nxt + d * pw;
                pw  = pw * 10;
            end
        end else if (en) begin
            if (up_dn) begin
                if (cur == top) begin
                    w   = 1'b1;
                    nxt = wr ? 0 : cur;
                end else begin
                    nxt = cur + 1;
                end
            end else begin
                if (cur == 0) begin
                    w   = 1'b1;
                    nxt = wr ? top : 0;
                end else begin
                    nxt = cur - 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned nd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(nd); i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
        end
    endtask

    // Drive one edge's inputs, predict its outcome and queue it for the monitor.
    task automatic cyc(input bit r, input bit c, input bit l, input logic [15:0] v,
                       input bit e, input bit u);
        exp_t x;
        reset = r; clear = c; load = l; lv = v; en = e; up_dn = u;
        mstep(2, 1'b1, ma, x.qa, x.wa, x.ea);
        mstep(2, 1'b0, mb, x.qb, x.wb, x.eb);
        mstep(4, 1'b1, mc, x.qc, x.wc, x.ec);
        ma = x.qa; mb = x.qb; mc = x.qc;
        sb.push_back(x);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("q_a",    32'(q_a), to_bcd(x.qa, 2));
            chk("q_b",    32'(q_b), to_bcd(x.qb, 2));
            chk("q_c",    32'(q_c), to_bcd(x.qc, 4));
            chk("wrap_a", 32'(w_a), 32'(x.wa));
            chk("wrap_b", 32'(w_b), 32'(x.wb));
            chk("wrap_c", 32'(w_c), 32'(x.wc));
            chk("err_a",  32'(e_a), 32'(x.ea));
            chk("err_b",  32'(e_b), 32'(x.eb));
            chk("err_c",  32'(e_c), 32'(x.ec));
            chk("tc_a", 32'(tc_a), 32'(up_dn ? (x.qa == 99) : (x.qa == 0)));
            chk("tc_b", 32'(tc_b), 32'(up_dn ? (x.qb == 99) : (x.qb == 0)));
            chk("tc_c", 32'(tc_c), 32'(up_dn ? (x.qc == 9999) : (x.qc == 0)));
        end
    end

    initial begin
        logic [15:0] v;
        ma = 0; mb = 0; mc = 0;

        // Reset with en high, then 12 up steps.
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        // Wrap upward from 98.
        cyc(1'b1, 1'b0, 1'b1, 16'h0098, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        // Borrow downward, then wrap below zero.
        cyc(1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        // Saturation beyond 99 on the non-wrapping instance.
        cyc(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        // Illegal digit in load, then clear beats load and en.
        cyc(1'b1, 1'b0, 1'b1, 16'hB0A7, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h0055, 1'b1, 1'b1);
        // 4-digit ripple to 1000, then reset on the following edge.
        cyc(1'b1, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 7))
                0: v = 16'h9999;
                1: v = 16'h0000;
                2: v = 16'h9998;
                3: v = 16'h0001;
                default: ;
            endcase
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) == 0, v, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)));
        end

        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updn_counter.md
BCD_UPDN_COUNTER -- requirements
Module: bcd_updn_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits; legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal values; 0 = saturate at terminal values.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port clear, input, 1: synchronous clear of count to zero, active-high.
REQ-007 Port load, input, 1: synchronous parallel load, active-high.
REQ-008 Port load_val, input, 4*DIGITS: BCD load value; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-009 Port en, input, 1: count enable, active-high.
REQ-010 Port up_dn, input, 1: 1 = count up, 0 = count down; sampled only when en=1.
REQ-011 Port q, output, 4*DIGITS: registered BCD count, same digit packing as load_val.
REQ-012 Port tc, output, 1: combinational terminal-count flag; 1 when q is all 9s and up_dn=1, or all 0s and up_dn=0.
REQ-013 Port wrap_p, output, 1: registered single-cycle pulse for the cycle after a wrap or saturation event.
REQ-014 Port load_err, output, 1: registered single-cycle pulse for the cycle after a load containing any digit >9.

Function
REQ-015 Each clock edge SHALL apply exactly one action, in priority order: reset, clear, load, count (en=1), hold.
REQ-016 Clear SHALL set q to 0 and wrap_p to 0; load_err SHALL be 0 in the following cycle.
REQ-017 Load SHALL copy load_val digit by digit; any digit >9 SHALL be stored as 0, with load_err=1 for one cycle.
REQ-018 Counting up SHALL increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit (ripple within the same cycle).
REQ-019 Counting down SHALL decrement digit 0; a digit at 0 SHALL go to 9 and borrow from the next digit.
REQ-020 Counting up from all 9s with WRAP=1 SHALL give all 0s with wrap_p=1 the next cycle.
REQ-021 Counting down from all 0s with WRAP=1 SHALL give all 9s with wrap_p=1 the next cycle.
REQ-022 With WRAP=0, counting beyond a terminal value SHALL hold q, and wrap_p SHALL pulse for every attempted step beyond it.
REQ-023 Count latency SHALL be one clock: q reflects the update on the edge where en=1 is sampled.
REQ-024 Hold (en=0, no load or clear) SHALL keep q unchanged, with wrap_p=0 and load_err=0.
REQ-025 up_dn SHALL be allowed to change on any cycle; direction takes effect at the next enabled edge, with no extra latency.
REQ-026 If load and en are both asserted, load SHALL win; no count step SHALL occur on that edge.
REQ-027 The digits of q SHALL never hold a value >9 after any edge.

Reset
REQ-028 When reset=0 at a rising edge, q SHALL be 0, wrap_p SHALL be 0 and load_err SHALL be 0, overriding all other inputs.
REQ-029 Reset asserted mid-count SHALL take effect at the next edge; counting SHALL resume from 0 on the first enabled edge after release.
REQ-030 Before the first reset edge, output values SHALL be undefined; benches SHALL NOT check them.

Verification (DIGITS=2 unless stated)
REQ-031 reset=0 for 2 edges with en=1, then release: q=0x00 during reset; after 12 enabled up edges, q=0x12 and tc=0.
REQ-032 Load 0x98, en=1, up_dn=1: q goes 0x99 then 0x00, wrap_p=1 exactly on the cycle after the 0x00 edge, and tc=1 while q=0x99.
REQ-033 Load 0x10, up_dn=0, 2 enabled edges: q goes 0x09 then 0x08; then from 0x00 with WRAP=1 one edge gives 0x99 and wrap_p=1.
REQ-034 WRAP=0, load 0x99, up_dn=1, 3 enabled edges: q stays 0x99 and wrap_p=1 for 3 consecutive cycles.
REQ-035 Load load_val=0xA7: q=0x07 and load_err=1 for one cycle; with load=1, en=1, clear=1 on one edge, q=0x00 (clear wins).
REQ-036 DIGITS=4, count up from 0x0999 with reset=0 on the edge after reaching 0x1000: q=0x1000, then 0x0000; the sweep stays BCD-legal on every cycle.
